// File: rtl/pwm_multi_ch_pkg.sv
// pwm_multi_ch_pkg: mode/select encodings and helpers shared by the multi-channel PWM
package pwm_multi_ch_pkg;
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  localparam logic [1:0] SEL_DUTY    = 2'd0;
  localparam logic [1:0] SEL_STEP    = 2'd1;
  localparam logic [1:0] SEL_MODE    = 2'd2;
  localparam logic [1:0] SEL_PERIOD  = 2'd3;
  typedef enum logic {UP, DN} dir_t;
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_multi_ch_ch.sv
// pwm_multi_ch_ch: one PWM channel with shadowed duty/step/mode and ramp/triangle stepping
module pwm_multi_ch_ch
  import pwm_multi_ch_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          bnd,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] p_n,
  input  logic          wr_duty,
  input  logic          wr_step,
  input  logic          wr_mode,
  input  logic [CW-1:0] data,
  output logic          pwm
);
  logic [CW-1:0] duty_sh, duty_act, step_sh, duty_w, step_w, nxt;
  logic [1:0] mode_sh, mode_act, mode_w;
  logic [CW:0] sum;
  logic dirty, ramp, load, up_hit, dn_hit;
  dir_t dir, dir_in, dir_nx;
  // Writes in the current clock are folded in so a boundary write lands directly in active.
  always_comb begin
    duty_w = wr_duty ? data : duty_sh;
    step_w = wr_step ? data : step_sh;
    mode_w = wr_mode ? data[1:0] : mode_sh;
    dir_in = (mode_w == MODE_TRI && mode_act != MODE_TRI) ? UP : dir;
    ramp = mode_w != MODE_STATIC && mode_w != MODE_RSVD;
    load = wr_duty || dirty || !ramp;
    sum = {1'b0, duty_act} + {1'b0, step_w};
    up_hit = sum >= {1'b0, p_n};
    dn_hit = duty_act < step_w;
    nxt = duty_act;
    dir_nx = dir_in;
    if (step_w != '0 && mode_w == MODE_RAMP)
      nxt = (sum > {1'b0, p_n}) ? '0 : sum[CW-1:0];
    else if (step_w != '0 && dir_in == UP) begin
      nxt = up_hit ? p_n : sum[CW-1:0];
      dir_nx = up_hit ? DN : UP;
    end else if (step_w != '0) begin
      nxt = dn_hit ? '0 : duty_act - step_w;
      dir_nx = dn_hit ? UP : DN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh <= '0;
      duty_act <= '0;
      step_sh <= '0;
      mode_sh <= MODE_STATIC;
      mode_act <= MODE_STATIC;
      dir <= UP;
      dirty <= 1'b0;
      pwm <= 1'b0;
    end else begin
      pwm <= en && (cnt < duty_act);
      duty_sh <= duty_w;
      step_sh <= step_w;
      mode_sh <= mode_w;
      if (!en) begin
        duty_act <= duty_w;
        mode_act <= mode_w;
        dirty <= 1'b0;
        dir <= UP;
      end else if (bnd) begin
        mode_act <= mode_w;
        dirty <= 1'b0;
        duty_act <= load ? duty_w : nxt;
        dir <= load ? dir_in : dir_nx;
      end else if (wr_duty) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: NCH PWM channels sharing one programmable period counter
module pwm_multi_ch
  import pwm_multi_ch_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = 8,
  parameter int PERIOD_RST = 99
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_we,
  input  logic [chw(NCH)-1:0]   cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [CW-1:0]         cfg_data,
  output logic [NCH-1:0]        pwm_out,
  output logic                  cyc_end
);
  logic [CW-1:0] cnt, p_act, p_sh, p_w;
  logic bnd;
  logic [NCH-1:0] wr_duty, wr_step, wr_mode;
  assign bnd = en && cnt == p_act;
  assign p_w = (cfg_we && cfg_sel == SEL_PERIOD) ? cfg_data : p_sh;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      p_act <= CW'(PERIOD_RST);
      p_sh <= CW'(PERIOD_RST);
      cyc_end <= 1'b0;
    end else begin
      cnt <= (en && !bnd) ? cnt + CW'(1) : '0;
      cyc_end <= bnd;
      p_sh <= p_w;
      if (!en || bnd) p_act <= p_w;
    end
  end
  // Channel indices at or above NCH never match, so such writes are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_duty[i] = cfg_we && cfg_sel == SEL_DUTY && int'(cfg_ch) == i;
    assign wr_step[i] = cfg_we && cfg_sel == SEL_STEP && int'(cfg_ch) == i;
    assign wr_mode[i] = cfg_we && cfg_sel == SEL_MODE && int'(cfg_ch) == i;
    pwm_multi_ch_ch #(.CW(CW)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .bnd(bnd),
      .cnt(cnt),
      .p_n(p_w),
      .wr_duty(wr_duty[i]),
      .wr_step(wr_step[i]),
      .wr_mode(wr_mode[i]),
      .data(cfg_data),
      .pwm(pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed and random stimulus checked against a period-level behavioural model
module tb_pwm_multi_ch;
  import pwm_multi_ch_pkg::*;
  localparam int NCH = 5;
  localparam int CW = 8;
  localparam int PR = 99;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [NCH-1:0] pwm_out;
  logic cyc_end;
  int n_cmp = 0;
  int n_err = 0;
  int m_cnt, m_p, m_psh, m_cyc;
  int d_sh[NCH], d_act[NCH], st[NCH], md_sh[NCH], md[NCH], up[NCH], pend[NCH], m_pwm[NCH];
  int hi[NCH];
  int ce;
  bit cur_en = 1'b0;

  pwm_multi_ch #(.NCH(NCH), .CW(CW), .PERIOD_RST(PR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
    .pwm_out(pwm_out),
    .cyc_end(cyc_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (m_pwm[i] != 0);
    return v;
  endfunction

  // Reference: one call per clock edge, using the inputs presented for that edge.
  task automatic model(input bit r, input bit e, input bit we, input int ch, input int sel, input int data);
    bit b, wd;
    int np, dsh, s, m, d;
    if (!r) begin
      m_cnt = 0; m_p = PR; m_psh = PR; m_cyc = 0;
      for (int i = 0; i < NCH; i++) begin
        d_sh[i] = 0; d_act[i] = 0; st[i] = 0; md_sh[i] = 0; md[i] = 0;
        up[i] = 1; pend[i] = 0; m_pwm[i] = 0;
      end
      return;
    end
    b = e && m_cnt == m_p;
    np = (we && sel == 3) ? data : m_psh;
    m_cyc = b;
    for (int i = 0; i < NCH; i++) begin
      wd = we && sel == 0 && ch == i;
      m_pwm[i] = e && m_cnt < d_act[i];
      dsh = wd ? data : d_sh[i];
      s = (we && sel == 1 && ch == i) ? data : st[i];
      m = (we && sel == 2 && ch == i) ? data % 4 : md_sh[i];
      if (!e) begin
        d_act[i] = dsh; md[i] = m; pend[i] = 0; up[i] = 1;
      end else if (b) begin
        if (m == 2 && md[i] != 2) up[i] = 1;
        md[i] = m;
        d = d_act[i];
        if (wd || pend[i] != 0 || (m != 1 && m != 2)) d = dsh;
        else if (s == 0) d = d;
        else if (m == 1) d = (d + s > np) ? 0 : d + s;
        else if (up[i] != 0) begin
          if (d + s >= np) begin d = np; up[i] = 0; end
          else d = d + s;
        end else if (d < s || d == 0) begin
          d = 0; up[i] = 1;
        end else d = d - s;
        d_act[i] = d;
        pend[i] = 0;
      end else if (wd) pend[i] = 1;
      d_sh[i] = dsh; st[i] = s; md_sh[i] = m;
    end
    m_cnt = (e && !b) ? m_cnt + 1 : 0;
    if (!e || b) m_p = np;
    m_psh = np;
  endtask

  task automatic tick(input bit r, input bit e, input bit we, input int ch, input int sel, input int data);
    rst_n = r; en = e; cfg_we = we;
    cfg_ch = ch[2:0]; cfg_sel = sel[1:0]; cfg_data = data[CW-1:0];
    model(r, e, we, ch, sel, data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
    ce += int'(cyc_end);
    chk("cyc_end", 32'(cyc_end), 32'(m_cyc));
    chk("pwm_out", 32'(pwm_out), pack());
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, cur_en, 1'b0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input logic [1:0] sel, input int data);
    tick(1'b1, cur_en, 1'b1, ch, int'(sel), data);
  endtask

  task automatic clr();
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    ce = 0;
  endtask

  task automatic count(input int n);
    clr();
    idle(n);
  endtask

  task automatic to_cnt(input int k);
    int g = 0;
    while (m_cnt != k && g < 1000) begin
      idle(1);
      g++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_tri[8] = '{0, 40, 80, 99, 59, 19, 0, 40};
    int sum_hi, sel, data;
    bit r, we;
    clr();
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_cyc", 32'(cyc_end), 0);
    wr(0, SEL_DUTY, 25);
    cur_en = 1'b1;
    count(100);
    chk("t1_hi25", hi[0], 25);
    chk("t1_cyc", ce, 1);
    count(100);
    chk("t1_hi25_b", hi[0], 25);
    chk("t1_cyc_b", ce, 1);
    to_cnt(50);
    wr(0, SEL_DUTY, 60);
    to_cnt(99);
    idle(1);
    count(100);
    chk("t2_hi60", hi[0], 60);
    to_cnt(99);
    wr(0, SEL_DUTY, 30);
    count(100);
    chk("t2_bnd_hi30", hi[0], 30);
    to_cnt(99);
    wr(0, SEL_DUTY, 0);
    count(100);
    chk("t3_duty0", hi[0], 0);
    to_cnt(99);
    wr(0, SEL_DUTY, 100);
    count(100);
    chk("t3_duty100", hi[0], 100);
    to_cnt(99);
    wr(0, SEL_PERIOD, 9);
    count(20);
    chk("t3_p9_hi", hi[0], 20);
    chk("t3_p9_cyc", ce, 2);
    to_cnt(0);
    wr(0, SEL_PERIOD, 99);
    wr(1, SEL_STEP, 5);
    wr(1, SEL_MODE, 1);
    wr(1, SEL_DUTY, 0);
    wr(2, SEL_STEP, 40);
    wr(2, SEL_MODE, 2);
    wr(2, SEL_DUTY, 0);
    to_cnt(9);
    idle(1);
    for (int k = 0; k <= 20; k++) begin
      count(100);
      chk($sformatf("t4_ramp%0d", k), hi[1], (5 * k) % 100);
      if (k < 8) chk($sformatf("t4_tri%0d", k), hi[2], exp_tri[k]);
    end
    to_cnt(40);
    cur_en = 1'b0;
    clr();
    idle(3);
    wr(0, SEL_DUTY, 70);
    wr(0, SEL_MODE, 0);
    idle(2);
    sum_hi = 0;
    for (int i = 0; i < NCH; i++) sum_hi += hi[i];
    chk("t5_en0_hi", sum_hi, 0);
    chk("t5_en0_cyc", ce, 0);
    cur_en = 1'b1;
    count(100);
    chk("t5_reen_hi70", hi[0], 70);
    chk("t5_reen_cyc", ce, 1);
    for (int i = 0; i < NCH; i++) begin
      wr(i, SEL_MODE, 0);
      wr(i, SEL_DUTY, 50 + i);
    end
    to_cnt(99);
    idle(1);
    to_cnt(30);
    chk("t6_all_on", 32'(pwm_out), 32'h1f);
    tick(1'b0, 1'b1, 1'b0, 0, 0, 0);
    chk("t6_rst_pwm", 32'(pwm_out), 0);
    chk("t6_rst_cyc", 32'(cyc_end), 0);
    wr(5, SEL_DUTY, 80);
    wr(7, SEL_DUTY, 200);
    count(100);
    sum_hi = 0;
    for (int i = 0; i < NCH; i++) sum_hi += hi[i];
    chk("t6_inv_ch", sum_hi, 0);
    chk("t6_cyc", ce, 1);
    for (int n = 0; n < 15000; n++) begin
      r = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 299) == 0) cur_en = !cur_en;
      we = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 3));
      data = (sel == 3) ? int'($urandom_range(0, 30)) :
             (sel == 1) ? int'($urandom_range(0, 12)) :
             (sel == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 40));
      tick(r, cur_en, we, int'($urandom_range(0, 7)), sel, data);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
